decode_regfile_stage: RTL and testbench

//  Instruction-decode / register-read stage directly downstream of INSTRUCTION_MEMORY.

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/decode_regfile_stage_reg_file.sv | 38 +++
 rtl/decode_regfile_stage.sv | 107 ++++++++++
 tb/tb_decode_regfile_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS-style decode pipeline.
//   - opcode_e   : supported R-type op field encodings
//   - alu_ctrl_e : ALU control codes driven into the execute stage
//   - *_MSB/*_LSB: instruction field bit positions
//   - decode_op  : op field -> ALU control (ALU_BAD for unsupported ops)
package mips_pkg;

  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_MSB = 10;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;

  typedef enum logic [5:0] {
    OP_AND = 6'b000000,
    OP_OR  = 6'b000001,
    OP_ADD = 6'b000010,
    OP_SUB = 6'b000110,
    OP_SLT = 6'b000111,
    OP_NOR = 6'b001100
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_BAD = 4'hF
  } alu_ctrl_e;

  function automatic alu_ctrl_e decode_op(input logic [5:0] op);
    alu_ctrl_e ctrl;
    case (op)
      OP_AND:  ctrl = ALU_AND;
      OP_OR:   ctrl = ALU_OR;
      OP_ADD:  ctrl = ALU_ADD;
      OP_SUB:  ctrl = ALU_SUB;
      OP_SLT:  ctrl = ALU_SLT;
      OP_NOR:  ctrl = ALU_NOR;
      default: ctrl = ALU_BAD;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/decode_regfile_stage_reg_file.sv
// reg_file: NREGS x DATA_W register file.
//   CLK, RESET   : clock, synchronous active-high clear of every register
//   rs_addr/rs_data, rt_addr/rt_data : asynchronous read ports
//   wb_en, wb_addr, wb_data          : synchronous write port
// Register 0 always reads zero and ignores writes.
module reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [$clog2(NREGS)-1:0] rs_addr,
  output logic [DATA_W-1:0]        rs_data,
  input  logic [$clog2(NREGS)-1:0] rt_addr,
  output logic [DATA_W-1:0]        rt_data,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [DATA_W-1:0]        wb_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_data = (rs_addr == '0) ? '0 : regs[rs_addr];
    rt_data = (rt_addr == '0) ? '0 : regs[rt_addr];
  end

endmodule

// File: rtl/decode_regfile_stage.sv
// decode_regfile_stage: ID / register-read stage feeding the ALU.
//   CLK, RESET              : clock, synchronous active-high reset
//   INSTRUCTION, PC_out     : R-type word and its PC from instruction memory
//   in_valid / in_ready     : upstream handshake
//   wb_en, wb_addr, wb_data : register-file write-back port
//   out_valid / out_ready   : downstream (ALU) handshake
//   alu_ctrl, rs_data, rt_data, rd_addr, shamt, pc_id, illegal : ID/EX register
module decode_regfile_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [31:0]              INSTRUCTION,
  input  logic [31:0]              PC_out,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               alu_ctrl,
  output logic [DATA_W-1:0]        rs_data,
  output logic [DATA_W-1:0]        rt_data,
  output logic [4:0]               rd_addr,
  output logic [4:0]               shamt,
  output logic [31:0]              pc_id,
  output logic                     illegal
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [AW-1:0]     rs_idx, rt_idx;
  logic [AW-1:0]     held_rs, held_rt;
  logic [DATA_W-1:0] rf_rs, rf_rt;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;
  logic              wb_live;
  logic              capture;
  alu_ctrl_e         dec_ctrl;
  logic              unused_funct;

  assign unused_funct = ^INSTRUCTION[FUNCT_MSB:FUNCT_LSB];

  assign rs_idx = INSTRUCTION[RS_MSB:RS_LSB];
  assign rt_idx = INSTRUCTION[RT_MSB:RT_LSB];

  reg_file #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_reg_file (
    .CLK     (CLK),
    .RESET   (RESET),
    .rs_addr (rs_idx),
    .rs_data (rf_rs),
    .rt_addr (rt_idx),
    .rt_data (rf_rt),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  always_comb begin
    in_ready = !RESET && (!out_valid || out_ready);
    capture  = in_valid && in_ready;
    wb_live  = wb_en && (wb_addr != '0);
    dec_ctrl = decode_op(INSTRUCTION[OP_MSB:OP_LSB]);
    // Write-first bypass: a same-cycle write-back wins over the stale array value.
    rs_fwd   = (wb_live && (wb_addr == rs_idx)) ? wb_data : rf_rs;
    rt_fwd   = (wb_live && (wb_addr == rt_idx)) ? wb_data : rf_rt;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid <= 1'b0;
      alu_ctrl  <= '0;
      rs_data   <= '0;
      rt_data   <= '0;
      rd_addr   <= '0;
      shamt     <= '0;
      pc_id     <= '0;
      illegal   <= 1'b0;
      held_rs   <= '0;
      held_rt   <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      alu_ctrl  <= dec_ctrl;
      rs_data   <= rs_fwd;
      rt_data   <= rt_fwd;
      rd_addr   <= INSTRUCTION[RD_MSB:RD_LSB];
      shamt     <= INSTRUCTION[SHAMT_MSB:SHAMT_LSB];
      pc_id     <= PC_out;
      illegal   <= (dec_ctrl == ALU_BAD);
      held_rs   <= rs_idx;
      held_rt   <= rt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      // A stalled entry tracks write-backs so it never presents a stale operand.
      if (wb_live && (wb_addr == held_rs)) rs_data <= wb_data;
      if (wb_live && (wb_addr == held_rt)) rt_data <= wb_data;
    end
  end

endmodule

// File: tb/tb_decode_regfile_stage.sv
module tb_decode_regfile_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC_out;
  logic        in_valid;
  logic        in_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [4:0]  rd_addr;
  logic [4:0]  shamt;
  logic [31:0] pc_id;
  logic        illegal;

  always #5 CLK = ~CLK;

  decode_regfile_stage #(
    .DATA_W (32),
    .NREGS  (32)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTRUCTION (INSTRUCTION),
    .PC_out      (PC_out),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_ctrl    (alu_ctrl),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .rd_addr     (rd_addr),
    .shamt       (shamt),
    .pc_id       (pc_id),
    .illegal     (illegal)
  );

  typedef struct {
    logic [3:0]  alu;
    logic [31:0] rsv;
    logic [31:0] rtv;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [31:0] pc;
    logic        ill;
    logic [4:0]  rsi;
    logic [4:0]  rti;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mregs[32];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference opcode table: {illegal, alu_ctrl}
  function automatic logic [4:0] ref_decode(input logic [5:0] op);
    case (op)
      6'd0:    return 5'b0_0000;
      6'd1:    return 5'b0_0001;
      6'd2:    return 5'b0_0010;
      6'd6:    return 5'b0_0110;
      6'd7:    return 5'b0_0111;
      6'd12:   return 5'b0_1100;
      default: return 5'b1_1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    logic [31:0] v;
    v = (idx == 5'd0) ? 32'd0 : mregs[idx];
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == idx)) v = wb_data;
    return v;
  endfunction

  // Check outputs at the negedge, then advance the model across the next posedge.
  task automatic cycle();
    logic       exp_ready;
    logic [4:0] dec;
    exp_t       e;
    exp_t       n;
    @(negedge CLK);
    exp_ready = !RESET && ((sb.size() == 0) || out_ready);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    check("out_valid", {31'd0, out_valid}, {31'd0, (sb.size() > 0)});
    if (sb.size() > 0) begin
      e = sb[0];
      check("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, e.alu});
      check("rs_data", rs_data, e.rsv);
      check("rt_data", rt_data, e.rtv);
      check("rd_addr", {27'd0, rd_addr}, {27'd0, e.rd});
      check("shamt", {27'd0, shamt}, {27'd0, e.sh});
      check("pc_id", pc_id, e.pc);
      check("illegal", {31'd0, illegal}, {31'd0, e.ill});
    end
    if (RESET) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      sb.delete();
    end else begin
      if ((sb.size() > 0) && !out_ready && wb_en && (wb_addr != 5'd0)) begin
        e = sb[0];
        if (e.rsi == wb_addr) e.rsv = wb_data;
        if (e.rti == wb_addr) e.rtv = wb_data;
        sb[0] = e;
      end
      if ((sb.size() > 0) && out_ready) void'(sb.pop_front());
      if (in_valid && exp_ready) begin
        dec   = ref_decode(INSTRUCTION[31:26]);
        n.alu = dec[3:0];
        n.ill = dec[4];
        n.rsi = INSTRUCTION[25:21];
        n.rti = INSTRUCTION[20:16];
        n.rsv = ref_read(n.rsi);
        n.rtv = ref_read(n.rti);
        n.rd  = INSTRUCTION[15:11];
        n.sh  = INSTRUCTION[10:6];
        n.pc  = PC_out;
        sb.push_back(n);
      end
      if (wb_en && (wb_addr != 5'd0)) mregs[wb_addr] = wb_data;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    wb_en    = 1'b0;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] pc);
    INSTRUCTION = {op, rs, rt, rd, sh, 6'h2A};
    PC_out      = pc;
    in_valid    = 1'b1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
  endtask

  initial begin
    RESET = 1'b1; INSTRUCTION = '0; PC_out = '0; in_valid = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Reset clears registers and the held entry
    wb(5'd5, 32'd7); cycle();
    idle(); send(6'd0, 5'd1, 5'd2, 5'd3, 5'd4, 32'h44); wb_en = 1'b0; cycle();
    RESET = 1'b1; in_valid = 1'b1; wb(5'd6, 32'h33); cycle();
    RESET = 1'b0; idle();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    check("rst_rs_data", rs_data, 32'd0);
    check("rst_pc_id", pc_id, 32'd0);
    send(6'd1, 5'd5, 5'd6, 5'd1, 5'd0, 32'h10); cycle();

    // ADD with r0 write ignored
    idle(); wb(5'd0, 32'd9); cycle();
    idle(); wb(5'd1, 32'd5); cycle();
    idle(); send(6'd2, 5'd0, 5'd1, 5'd2, 5'd3, 32'h100); cycle();
    idle(); cycle();

    // Same-cycle bypass on rs
    send(6'd6, 5'd9, 5'd10, 5'd4, 5'd0, 32'h104); wb(5'd9, 32'h64); cycle();
    idle(); cycle();

    // Stall with refresh of the held operand
    out_ready = 1'b0;
    send(6'd12, 5'd15, 5'd1, 5'd3, 5'd0, 32'h108); cycle();
    send(6'd0, 5'd2, 5'd2, 5'd2, 5'd0, 32'hBAD); wb(5'd15, 32'hA5); cycle();
    idle(); wb(5'd1, 32'h5A); cycle();
    idle(); cycle();
    out_ready = 1'b1; cycle();
    cycle();

    // Back-to-back stream, no bubbles
    send(6'd0, 5'd1, 5'd15, 5'd7, 5'd1, 32'h200); cycle();
    send(6'd1, 5'd9, 5'd1, 5'd8, 5'd2, 32'h204); cycle();
    send(6'd7, 5'd15, 5'd9, 5'd9, 5'd3, 32'h208); cycle();
    idle(); cycle();
    cycle();

    // Illegal opcode, then reset while held
    send(6'h3F, 5'd1, 5'd9, 5'd31, 5'd31, 32'hFFFC); cycle();
    idle(); out_ready = 1'b0; cycle();
    cycle();
    RESET = 1'b1; cycle();
    RESET = 1'b0; out_ready = 1'b1;
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_out_valid2", {31'd0, out_valid}, 32'd0);
    cycle();

    // Mixed traffic
    for (int k = 0; k < 60; k++) begin
      idle();
      if ($urandom_range(0, 3) != 0) begin
        send($urandom_range(0, 13), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
      end
      if ($urandom_range(0, 1) != 0) wb($urandom_range(0, 7), $urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    idle(); out_ready = 1'b1; cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
